memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
Sits between the cache-side request interface (iREN from fetch, dREN/dWEN from the request unit) and the single-ported RAM. It serialises instruction and data accesses onto one RAM port, with data taking priority. It returns single-cycle ihit/dhit pulses with load data. A watchdog aborts transactions the RAM never completes.

Parameters:
TIMEOUT, 255, max cycles a granted transaction may wait without ramstate==ACCESS before abort (1..65535)
CNT_W, 16, width of watchdog counter; must hold TIMEOUT

Ports:
CLK  input  1  system clock, all state on rising edge
nRST  input  1  asynchronous active-low reset
iREN  input  1  instruction read request, held until ihit
iaddr  input  32  instruction byte address
dREN  input  1  data read request, held until dhit
dWEN  input  1  data write request, held until dhit
daddr  input  32  data byte address
dstore  input  32  data write value
ramstate  input  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
ramload  input  32  RAM read data, valid when ramstate==ACCESS
ihit  output  1  instruction access complete, 1-cycle pulse
dhit  output  1  data access complete, 1-cycle pulse
iload  output  32  instruction word, valid with ihit
dload  output  32  data word, valid with dhit on reads
ramREN  output  1  RAM read strobe
ramWEN  output  1  RAM write strobe
ramaddr  output  32  RAM address
ramstore  output  32  RAM write data
err  output  1  transaction aborted (timeout or ERROR), 1-cycle pulse

Behaviour:
- Clock is CLK. Reset is nRST, asynchronous and active-low. Reset forces state IDLE, counter 0, and all latched request registers to 0. All outputs are 0 during and after reset until a grant.
- States: IDLE, DGRANT, IGRANT.
- IDLE: if dREN|dWEN, latch daddr, dstore and op, then go to DGRANT. Else if iREN, latch iaddr and go to IGRANT. Else stay. Latching happens at the edge; no RAM strobes in the IDLE cycle.
- Write precedence: dREN and dWEN both high is treated as a write (ramWEN=1, ramREN=0).
- DGRANT: ramaddr = latched daddr; ramstore = latched dstore; ramREN/ramWEN per latched op.
- IGRANT: ramREN=1; ramaddr = latched iaddr; ramstore=0.
- Outputs in both grant states are driven from the latched registers only. Requester input changes during a grant are ignored.
- Completion: in the cycle ramstate==ACCESS, drive dhit=1 (DGRANT) or ihit=1 (IGRANT) combinationally.
  - The same cycle: dload=ramload or iload=ramload, otherwise 0.
  - Next state is IDLE, so a back-to-back request has one idle cycle between grants.
- Requester dropping its request mid-grant: the transaction still completes and the hit still pulses.
- Watchdog: counter clears on entry to a grant state. It increments each grant cycle where ramstate is not ACCESS.
  - If the counter equals TIMEOUT and ramstate is not ACCESS: err=1 for that cycle, no hit, next state IDLE.
  - Counter saturates; no wrap.
- ramstate==ERROR in a grant state: err=1 that cycle, no hit, next state IDLE. ERROR takes precedence over the timeout check.
- ramstate in IDLE is ignored.
- Reset asserted mid-grant: immediate abort. Strobes drop asynchronously and no hit or err is produced.
- Priority is strict data-over-instruction and is evaluated only in IDLE. A grant is never preempted.

Test Plan:
1. Reset mid-DGRANT (ramstate=BUSY) -> ramREN/ramWEN/dhit/err drop to 0 immediately; after release with no requests, all outputs stay 0.
2. iREN=1, iaddr=0x00000040; ramstate BUSY for 2 cycles then ACCESS with ramload=0x24080005.
   - ramREN=1, ramaddr=0x40 for 3 cycles.
   - ihit=1 with iload=0x24080005 in the third cycle only; state IDLE next.
3. iREN and dREN rise together, daddr=0x80, iaddr=0x44, ACCESS after 1 BUSY each.
   - Data grant first: dhit with dload=ramload.
   - One IDLE cycle, then instruction grant with ramaddr=0x44, then ihit.
4. dWEN=1 and dREN=1, daddr=0x100, dstore=0xDEADBEEF.
   - ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
   - Change dstore to 0 mid-grant -> ramstore unchanged; dhit on ACCESS.
5. TIMEOUT=4, iREN held, ramstate held BUSY -> err=1 exactly on grant cycle 5, no ihit, IDLE next cycle, then re-grant since iREN is still high.
6. dREN grant, ramstate=ERROR on cycle 2 -> err=1 that cycle, dhit=0, ramREN=0 the following cycle.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// Bundle of cache-side request signals and single-port RAM signals that pass through the memory arbiter.
// The arbiter uses the slave view; the requester/RAM environment uses the master view.
interface memory_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [1:0]  ramstate;
  logic [31:0] ramload;
  logic        ihit;
  logic        dhit;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic        err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    output ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    input  ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/memory_arbiter.sv
// Serialises instruction and data accesses onto one RAM port (data first), with hit pulses
// on completion and a watchdog that aborts grants the RAM never finishes.
module memory_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input logic             CLK,
  input logic             nRST,
  memory_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } state_t;

  localparam logic [1:0]       RAM_ACCESS = 2'd2;
  localparam logic [1:0]       RAM_ERROR  = 2'd3;
  localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t            state_q;
  logic [31:0]       addr_q;
  logic [31:0]       store_q;
  logic              wr_q;
  logic              rd_q;
  logic [CNT_W-1:0]  cnt_q;

  logic access_s;
  logic error_s;
  logic timeout_s;
  logic finish_s;

  // Classify the RAM status for the current grant cycle; ERROR outranks the watchdog.
  always_comb begin
    access_s  = (bus.ramstate == RAM_ACCESS);
    error_s   = (bus.ramstate == RAM_ERROR);
    timeout_s = !access_s && !error_s && (cnt_q == CNT_LIMIT);
    finish_s  = access_s || error_s || timeout_s;
  end

  // Arbitration FSM: latches the winning request in IDLE and holds it until completion or abort.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      addr_q  <= 32'h0000_0000;
      store_q <= 32'h0000_0000;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= {CNT_W{1'b0}};
          if (bus.dREN || bus.dWEN) begin
            addr_q  <= bus.daddr;
            store_q <= bus.dstore;
            wr_q    <= bus.dWEN;
            rd_q    <= bus.dREN && !bus.dWEN;
            state_q <= DGRANT;
          end else if (bus.iREN) begin
            addr_q  <= bus.iaddr;
            store_q <= 32'h0000_0000;
            wr_q    <= 1'b0;
            rd_q    <= 1'b1;
            state_q <= IGRANT;
          end else begin
            state_q <= IDLE;
          end
        end
        DGRANT, IGRANT: begin
          if (finish_s) begin
            state_q <= IDLE;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            cnt_q <= cnt_q;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // RAM strobes come only from latched state; hits and err are same-cycle responses to ramstate.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = 32'h0000_0000;
    bus.ramstore = 32'h0000_0000;
    bus.ihit     = 1'b0;
    bus.dhit     = 1'b0;
    bus.iload    = 32'h0000_0000;
    bus.dload    = 32'h0000_0000;
    bus.err      = 1'b0;
    case (state_q)
      DGRANT: begin
        bus.ramREN   = rd_q;
        bus.ramWEN   = wr_q;
        bus.ramaddr  = addr_q;
        bus.ramstore = store_q;
        if (error_s || timeout_s) begin
          bus.err = 1'b1;
        end else if (access_s) begin
          bus.dhit  = 1'b1;
          bus.dload = bus.ramload;
        end else begin
          bus.err = 1'b0;
        end
      end
      IGRANT: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = addr_q;
        if (error_s || timeout_s) begin
          bus.err = 1'b1;
        end else if (access_s) begin
          bus.ihit  = 1'b1;
          bus.iload = bus.ramload;
        end else begin
          bus.err = 1'b0;
        end
      end
      default: begin
        bus.err = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: each task drives one scenario and checks outputs mid-cycle.
module tb_memory_arbiter;

  logic CLK;
  logic nRST;
  int   checks;
  int   errors;

  memory_arbiter_if bus ();

  memory_arbiter #(.TIMEOUT(4), .CNT_W(16)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge; inputs are changed there and outputs sampled #1 later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    bus.iREN = 1'b0; bus.iaddr = 32'h0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.daddr = 32'h0; bus.dstore = 32'h0; bus.ramstate = 2'd0; bus.ramload = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if ({bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit, bus.err} !== 5'b00000) begin errors++; $display("FAIL rst_ctrl got %b want 00000", {bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit, bus.err}); end
    checks++; if (bus.ramaddr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 00000000", bus.ramaddr); end
    nRST = 1'b1;
    tick();
    bus.dREN = 1'b1; bus.daddr = 32'h10; bus.dstore = 32'h77; bus.ramstate = 2'd1;
    tick();
    checks++; if (bus.ramREN !== 1'b1) begin errors++; $display("FAIL rst_pre_grant ramREN got %b want 1", bus.ramREN); end
    nRST = 1'b0;
    #1;
    checks++; if ({bus.ramREN, bus.ramWEN, bus.dhit, bus.err} !== 4'b0000) begin errors++; $display("FAIL rst_mid_grant got %b want 0000", {bus.ramREN, bus.ramWEN, bus.dhit, bus.err}); end
    bus.dREN = 1'b0;
    nRST = 1'b1;
    tick();
    bus.ramstate = 2'd2; bus.ramload = 32'hCAFE0001;
    #1;
    checks++; if ({bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit, bus.err} !== 5'b00000) begin errors++; $display("FAIL idle_ignores_ram got %b want 00000", {bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit, bus.err}); end
    checks++; if ({bus.iload, bus.dload} !== 64'h0) begin errors++; $display("FAIL idle_loads got %h want 0", {bus.iload, bus.dload}); end
    tick();
    bus.ramstate = 2'd0;
  endtask

  task automatic test_instr_fetch();
    bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = 2'd1;
    #1;
    checks++; if (bus.ramREN !== 1'b0) begin errors++; $display("FAIL if_idle_strobe got %b want 0", bus.ramREN); end
    for (int c = 1; c <= 2; c++) begin
      tick();
      checks++; if ({bus.ramREN, bus.ihit, bus.ramaddr} !== {1'b1, 1'b0, 32'h40}) begin errors++; $display("FAIL if_busy%0d got ren=%b hit=%b addr=%h want 1 0 00000040", c, bus.ramREN, bus.ihit, bus.ramaddr); end
    end
    tick();
    bus.ramstate = 2'd2; bus.ramload = 32'h24080005;
    #1;
    checks++; if ({bus.ramREN, bus.ihit, bus.ramaddr} !== {1'b1, 1'b1, 32'h40}) begin errors++; $display("FAIL if_access got ren=%b hit=%b addr=%h want 1 1 00000040", bus.ramREN, bus.ihit, bus.ramaddr); end
    checks++; if (bus.iload !== 32'h24080005) begin errors++; $display("FAIL if_iload got %h want 24080005", bus.iload); end
    bus.iREN = 1'b0;
    tick();
    bus.ramstate = 2'd0;
    #1;
    checks++; if ({bus.ramREN, bus.ihit, bus.iload} !== {1'b0, 1'b0, 32'h0}) begin errors++; $display("FAIL if_after got ren=%b hit=%b iload=%h want 0 0 0", bus.ramREN, bus.ihit, bus.iload); end
  endtask

  task automatic test_priority();
    bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.dREN = 1'b1; bus.daddr = 32'h80; bus.ramstate = 2'd1;
    tick();
    checks++; if ({bus.ramREN, bus.dhit, bus.ramaddr} !== {1'b1, 1'b0, 32'h80}) begin errors++; $display("FAIL pri_dgrant got ren=%b dhit=%b addr=%h want 1 0 00000080", bus.ramREN, bus.dhit, bus.ramaddr); end
    tick();
    bus.ramstate = 2'd2; bus.ramload = 32'h11112222;
    #1;
    checks++; if ({bus.dhit, bus.ihit, bus.dload} !== {1'b1, 1'b0, 32'h11112222}) begin errors++; $display("FAIL pri_dhit got dhit=%b ihit=%b dload=%h want 1 0 11112222", bus.dhit, bus.ihit, bus.dload); end
    bus.dREN = 1'b0;
    tick();
    bus.ramstate = 2'd0;
    #1;
    checks++; if ({bus.ramREN, bus.dhit, bus.ihit} !== 3'b000) begin errors++; $display("FAIL pri_gap got %b want 000", {bus.ramREN, bus.dhit, bus.ihit}); end
    tick();
    bus.ramstate = 2'd1;
    #1;
    checks++; if ({bus.ramREN, bus.ramWEN, bus.ramaddr} !== {1'b1, 1'b0, 32'h44}) begin errors++; $display("FAIL pri_igrant got ren=%b wen=%b addr=%h want 1 0 00000044", bus.ramREN, bus.ramWEN, bus.ramaddr); end
    tick();
    bus.ramstate = 2'd2; bus.ramload = 32'h33334444;
    #1;
    checks++; if ({bus.ihit, bus.iload} !== {1'b1, 32'h33334444}) begin errors++; $display("FAIL pri_ihit got ihit=%b iload=%h want 1 33334444", bus.ihit, bus.iload); end
    bus.iREN = 1'b0;
    tick();
    bus.ramstate = 2'd0;
  endtask

  task automatic test_write();
    bus.dWEN = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF; bus.ramstate = 2'd1;
    tick();
    checks++; if ({bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore} !== {1'b1, 1'b0, 32'h100, 32'hDEADBEEF}) begin errors++; $display("FAIL wr_grant got wen=%b ren=%b addr=%h store=%h want 1 0 00000100 deadbeef", bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore); end
    bus.dstore = 32'h0; bus.daddr = 32'h200;
    #1;
    checks++; if ({bus.ramaddr, bus.ramstore} !== {32'h100, 32'hDEADBEEF}) begin errors++; $display("FAIL wr_hold got addr=%h store=%h want 00000100 deadbeef", bus.ramaddr, bus.ramstore); end
    tick();
    bus.ramstate = 2'd2;
    #1;
    checks++; if ({bus.dhit, bus.ramWEN, bus.ramstore} !== {1'b1, 1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL wr_dhit got dhit=%b wen=%b store=%h want 1 1 deadbeef", bus.dhit, bus.ramWEN, bus.ramstore); end
    bus.dWEN = 1'b0; bus.dREN = 1'b0;
    tick();
    bus.ramstate = 2'd0;
    #1;
    checks++; if ({bus.ramWEN, bus.dhit, bus.ramstore} !== {1'b0, 1'b0, 32'h0}) begin errors++; $display("FAIL wr_after got wen=%b dhit=%b store=%h want 0 0 0", bus.ramWEN, bus.dhit, bus.ramstore); end
  endtask

  task automatic test_timeout();
    bus.iREN = 1'b1; bus.iaddr = 32'h48; bus.ramstate = 2'd1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++; if ({bus.ramREN, bus.ihit, bus.err} !== 3'b100) begin errors++; $display("FAIL to_wait%0d got ren/hit/err=%b want 100", c, {bus.ramREN, bus.ihit, bus.err}); end
    end
    tick();
    checks++; if ({bus.ramREN, bus.ihit, bus.err} !== 3'b101) begin errors++; $display("FAIL to_abort got ren/hit/err=%b want 101", {bus.ramREN, bus.ihit, bus.err}); end
    tick();
    checks++; if ({bus.ramREN, bus.ihit, bus.err} !== 3'b000) begin errors++; $display("FAIL to_idle got ren/hit/err=%b want 000", {bus.ramREN, bus.ihit, bus.err}); end
    tick();
    checks++; if ({bus.ramREN, bus.err, bus.ramaddr} !== {1'b1, 1'b0, 32'h48}) begin errors++; $display("FAIL to_regrant got ren=%b err=%b addr=%h want 1 0 00000048", bus.ramREN, bus.err, bus.ramaddr); end
    bus.ramstate = 2'd2; bus.ramload = 32'h0000ABCD;
    #1;
    checks++; if ({bus.ihit, bus.iload} !== {1'b1, 32'h0000ABCD}) begin errors++; $display("FAIL to_regrant_hit got ihit=%b iload=%h want 1 0000abcd", bus.ihit, bus.iload); end
    bus.iREN = 1'b0;
    tick();
    bus.ramstate = 2'd0;
  endtask

  task automatic test_error();
    bus.dREN = 1'b1; bus.daddr = 32'h84; bus.ramstate = 2'd1;
    tick();
    checks++; if ({bus.ramREN, bus.err, bus.dhit} !== 3'b100) begin errors++; $display("FAIL er_c1 got ren/err/hit=%b want 100", {bus.ramREN, bus.err, bus.dhit}); end
    tick();
    bus.ramstate = 2'd3; bus.ramload = 32'h99999999;
    #1;
    checks++; if ({bus.err, bus.dhit, bus.dload} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL er_abort got err=%b dhit=%b dload=%h want 1 0 0", bus.err, bus.dhit, bus.dload); end
    bus.dREN = 1'b0;
    tick();
    bus.ramstate = 2'd0;
    #1;
    checks++; if ({bus.ramREN, bus.err, bus.dhit} !== 3'b000) begin errors++; $display("FAIL er_after got ren/err/hit=%b want 000", {bus.ramREN, bus.err, bus.dhit}); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_instr_fetch();
    test_priority();
    test_write();
    test_timeout();
    test_error();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
